// File: rtl/digger_pkg.sv
// Shared types for the digger gold-bag logic: bag state encoding, coordinates, floor limit.
package digger_pkg;

  typedef logic [10:0] coord_t;

  localparam coord_t FLOOR_Y = 11'd416;

  localparam int unsigned TimerWidth = 16;

  // Collision stage treats 1 as lethal and 2 as edible.
  typedef enum logic [3:0] {
    GoldRest    = 4'd0,
    GoldFalling = 4'd1,
    GoldBroken  = 4'd2,
    GoldWobble  = 4'd3,
    GoldGone    = 4'd4
  } gold_state_t;

endpackage

// File: rtl/frame_timer.sv
// Loadable per-frame down-counter; expire_o marks the tick that brings it to zero.
module frame_timer
  import digger_pkg::TimerWidth;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_i,
  input  logic                  load_i,
  input  logic [TimerWidth-1:0] load_val_i,
  output logic                  expire_o
);

  logic [TimerWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - TimerWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = tick_i && (count_q <= TimerWidth'(1));

endmodule

// File: rtl/gold_bag_ctrl.sv
// Gold bag behaviour: rest, wobble, fall, break, eaten. GOLD_BROKEN_TIMEOUT_EN adds a
// lifetime to broken bags; otherwise a broken bag waits to be eaten.
module gold_bag_ctrl
  import digger_pkg::coord_t;
  import digger_pkg::gold_state_t;
  import digger_pkg::TimerWidth;
  import digger_pkg::GoldRest;
  import digger_pkg::GoldFalling;
  import digger_pkg::GoldBroken;
  import digger_pkg::GoldWobble;
  import digger_pkg::GoldGone;
#(
  parameter coord_t      INIT_X        = 11'd256,
  parameter coord_t      INIT_Y        = 11'd96,
  parameter int unsigned FALL_SPEED    = 4,
  parameter int unsigned WOBBLE_FRAMES = 15,
  parameter int unsigned BREAK_DIST    = 32,
  parameter int unsigned BROKEN_FRAMES = 150,
  parameter coord_t      FLOOR_Y       = digger_pkg::FLOOR_Y
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        support_below,
  input  logic        collision_gold,
  input  logic        player_eat_gold,
  output logic [3:0]  gold_state,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        gold_visible,
  output logic        gold_eaten
);

  gold_state_t state_q, state_d;
  coord_t      y_q, y_d;
  logic [7:0]  dist_q, dist_d;
  logic        eat_flag_q, eat_flag_d;
  logic        push_flag_q, push_flag_d;
  logic        eaten_q, eaten_d;

  logic                  timer_tick, timer_load, timer_expire;
  logic [TimerWidth-1:0] timer_load_val;

  logic [11:0] y_sum, dist_sum;
  coord_t      y_step, step_amt;
  logic [7:0]  dist_step;
  logic        eat_now, landing;

  frame_timer u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (timer_tick),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .expire_o   (timer_expire)
  );

  // Saturating fall step; the distance grows by the pixels actually moved.
  always_comb begin
    y_sum     = {1'b0, y_q} + 12'(FALL_SPEED);
    y_step    = (y_sum >= {1'b0, FLOOR_Y}) ? FLOOR_Y : y_sum[10:0];
    step_amt  = y_step - y_q;
    dist_sum  = {4'b0, dist_q} + {1'b0, step_amt};
    dist_step = (dist_sum > 12'd255) ? 8'hFF : dist_sum[7:0];
    landing   = support_below || (y_q == FLOOR_Y);
  end

  assign eat_now = eat_flag_q || player_eat_gold;

  always_comb begin
    eat_flag_d  = startOfFrame ? 1'b0 : (eat_flag_q || player_eat_gold);
    push_flag_d = startOfFrame ? 1'b0 : (push_flag_q || collision_gold);

    state_d        = state_q;
    y_d            = y_q;
    dist_d         = dist_q;
    eaten_d        = 1'b0;
    timer_tick     = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = '0;

    if (startOfFrame) begin
      unique case (state_q)
        GoldRest: begin
          if (!support_below) begin
            state_d        = GoldWobble;
            timer_load     = 1'b1;
            timer_load_val = TimerWidth'(WOBBLE_FRAMES);
          end
        end
        GoldWobble: begin
          timer_tick = 1'b1;
          if (support_below) begin
            state_d = GoldRest;
          end else if (timer_expire) begin
            state_d = GoldFalling;
            dist_d  = '0;
          end
        end
        GoldFalling: begin
          if (landing) begin
            if (32'(dist_q) >= BREAK_DIST) begin
              state_d = GoldBroken;
`ifdef GOLD_BROKEN_TIMEOUT_EN
              timer_load     = 1'b1;
              timer_load_val = TimerWidth'(BROKEN_FRAMES);
`endif
            end else begin
              state_d = GoldRest;
            end
          end else begin
            y_d    = y_step;
            dist_d = dist_step;
          end
        end
        GoldBroken: begin
          // Eating takes priority over the lifetime running out on the same frame.
          if (eat_now) begin
            state_d = GoldGone;
            eaten_d = 1'b1;
          end
`ifdef GOLD_BROKEN_TIMEOUT_EN
          else begin
            timer_tick = 1'b1;
            if (timer_expire) begin
              state_d = GoldGone;
            end
          end
`endif
        end
        GoldGone: begin
          state_d = GoldGone;
        end
        default: begin
          state_d = GoldRest;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GoldRest;
      y_q         <= INIT_Y;
      dist_q      <= '0;
      eat_flag_q  <= 1'b0;
      push_flag_q <= 1'b0;
      eaten_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      dist_q      <= dist_d;
      eat_flag_q  <= eat_flag_d;
      push_flag_q <= push_flag_d;
      eaten_q     <= eaten_d;
    end
  end

  // Push flag is captured for the future push logic and not consumed yet.
  logic unused_push_flag;
  assign unused_push_flag = push_flag_q;

`ifndef GOLD_BROKEN_TIMEOUT_EN
  localparam int unsigned unused_broken_frames = BROKEN_FRAMES;
`endif

  assign gold_state   = state_q;
  assign topLeftX     = INIT_X;
  assign topLeftY     = y_q;
  assign gold_visible = (state_q != GoldGone);
  assign gold_eaten   = eaten_q;

endmodule

// File: tb/tb_gold_bag_ctrl.sv
// Scoreboard bench for gold_bag_ctrl against a frame-level behavioural model of the bag.
module tb_gold_bag_ctrl;

  localparam int StRest = 0, StFall = 1, StBroken = 2, StWobble = 3, StGone = 4;
  localparam int InitX = 256, InitY = 96, Speed = 4, WobbleN = 15, BreakDist = 32;
  localparam int BrokenN = 150, FloorY = 416;
`ifdef GOLD_BROKEN_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        support_below = 1'b0;
  logic        collision_gold = 1'b0;
  logic        player_eat_gold = 1'b0;
  logic [3:0]  gold_state;
  logic [10:0] topLeftX, topLeftY;
  logic        gold_visible, gold_eaten;

  gold_bag_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .support_below   (support_below),
    .collision_gold  (collision_gold),
    .player_eat_gold (player_eat_gold),
    .gold_state      (gold_state),
    .topLeftX        (topLeftX),
    .topLeftY        (topLeftY),
    .gold_visible    (gold_visible),
    .gold_eaten      (gold_eaten)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int y;
    bit vis;
    bit eaten;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;
  logic pop_due = 1'b0;

  // Reference model: whole-frame view of the bag.
  int m_state, m_y, m_dist, m_age;
  bit m_eat_pend;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t snapshot(input bit eaten);
    exp_t e;
    e.st    = m_state;
    e.y     = m_y;
    e.vis   = (m_state != StGone);
    e.eaten = eaten;
    return e;
  endfunction

  task automatic model_reset();
    m_state = StRest; m_y = InitY; m_dist = 0; m_age = 0; m_eat_pend = 1'b0;
  endtask

  task automatic model_frame(input bit sup, output bit eaten);
    int step;
    eaten = 1'b0;
    case (m_state)
      StRest:   if (!sup) begin m_state = StWobble; m_age = 1; end
      StWobble: begin
        if (sup) m_state = StRest;
        else if (m_age >= WobbleN) begin m_state = StFall; m_dist = 0; end
        else m_age++;
      end
      StFall: begin
        if (sup || m_y == FloorY) begin
          if (m_dist >= BreakDist) begin m_state = StBroken; m_age = 1; end
          else m_state = StRest;
        end else begin
          step = (FloorY - m_y < Speed) ? FloorY - m_y : Speed;
          m_y += step;
          m_dist = (m_dist + step > 255) ? 255 : m_dist + step;
        end
      end
      StBroken: begin
        if (m_eat_pend) begin m_state = StGone; eaten = 1'b1; end
        else if (TimeoutEn && m_age >= BrokenN) m_state = StGone;
        else m_age++;
      end
      default: ;
    endcase
    m_eat_pend = 1'b0;
  endtask

  // One frame: SOF cycle, then three cycles with optional mid-frame eat pulse.
  task automatic do_frame(input bit sup, input bit eat);
    bit e;
    @(posedge clk); #1;
    startOfFrame = 1'b1; support_below = sup; collision_gold = 1'($urandom);
    model_frame(sup, e);
    q.push_back(snapshot(e));
    @(posedge clk); #1;
    startOfFrame = 1'b0; support_below = 1'($urandom); collision_gold = 1'($urandom);
    player_eat_gold = eat;
    if (eat) m_eat_pend = 1'b1;
    @(posedge clk); #1;
    player_eat_gold = 1'b0; collision_gold = 1'($urandom);
    @(posedge clk); #1;
    collision_gold = 1'b0;
  endtask

  task automatic do_frames(input int n, input bit sup);
    for (int i = 0; i < n; i++) do_frame(sup, 1'b0);
  endtask

  task automatic do_reset(input bit with_sof);
    @(posedge clk); #1;
    reset = 1'b1; startOfFrame = with_sof; support_below = 1'($urandom);
    armed = 1'b1;
    model_reset();
    q.push_back(snapshot(1'b0));
    @(posedge clk); #1;
    reset = 1'b0; startOfFrame = 1'b0;
  endtask

  always @(posedge clk) pop_due <= startOfFrame | reset;

  // Monitor: outputs change only after a SOF or reset edge; check those, and eaten every cycle.
  always @(negedge clk) begin
    if (armed) begin
      if (pop_due) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("state", 32'(gold_state), 32'(e.st));
          chk("top_y", 32'(topLeftY), 32'(e.y));
          chk("top_x", 32'(topLeftX), 32'(InitX));
          chk("visible", 32'(gold_visible), 32'(e.vis));
          chk("eaten", 32'(gold_eaten), 32'(e.eaten));
        end
      end else begin
        chk("eaten_idle", 32'(gold_eaten), 32'd0);
      end
    end
  end

  initial begin
    int psup;
    model_reset();

    // Wobble 15 frames, fall 40 px, land and break, then eat.
    do_reset(1'b0);
    do_frames(16, 1'b0);
    chk("fall_start", 32'(gold_state), 32'(StFall));
    do_frames(10, 1'b0);
    do_frame(1'b1, 1'b0);
    chk("broken_40", 32'(gold_state), 32'(StBroken));
    chk("broken_y", 32'(topLeftY), 32'd136);
    do_frame(1'b1, 1'b1);
    do_frame(1'b1, 1'b0);
    chk("gone", 32'(gold_state), 32'(StGone));
    chk("gone_vis", 32'(gold_visible), 32'd0);
    do_frames(3, 1'b0);

    // Support returns on wobble frame 7.
    do_reset(1'b0);
    do_frames(7, 1'b0);
    do_frame(1'b1, 1'b0);
    chk("wob_back", 32'(gold_state), 32'(StRest));
    chk("wob_y", 32'(topLeftY), 32'd96);

    // Short 16 px fall returns to rest.
    do_reset(1'b0);
    do_frames(20, 1'b0);
    do_frame(1'b1, 1'b0);
    chk("short_st", 32'(gold_state), 32'(StRest));
    chk("short_y", 32'(topLeftY), 32'd112);

    // Fall to the floor, then let the broken bag age.
    do_reset(1'b0);
    do_frames(16 + 82, 1'b0);
    chk("floor_y", 32'(topLeftY), 32'd416);
    chk("floor_st", 32'(gold_state), 32'(StBroken));
    do_frames(BrokenN + 2, 1'b0);

    // Reset mid-fall at Y=200, coinciding with a frame start.
    do_reset(1'b0);
    do_frames(16 + 26, 1'b0);
    chk("fall_200", 32'(topLeftY), 32'd200);
    do_reset(1'b1);
    chk("rst_st", 32'(gold_state), 32'(StRest));
    chk("rst_y", 32'(topLeftY), 32'd96);
    do_frames(16, 1'b0);

    // Random segments with varying support density and frequent eat pulses.
    do_reset(1'b0);
    for (int seg = 0; seg < 12; seg++) begin
      psup = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 30 : 70);
      for (int f = 0; f < 35; f++) begin
        if ($urandom_range(0, 199) == 0) do_reset(1'($urandom));
        else do_frame($urandom_range(0, 99) < psup, $urandom_range(0, 3) == 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gold_bag_ctrl.md
GOLD_BAG_CTRL -- requirements
Module: gold_bag_ctrl

Interface
REQ-001 Parameter INIT_X, default 11'd256, bag top-left X in pixels, constant.
REQ-002 Parameter INIT_Y, default 11'd96, bag top-left Y after reset.
REQ-003 Parameter FALL_SPEED, default 4, pixels added to Y per frame while FALLING.
REQ-004 Parameter WOBBLE_FRAMES, default 15, frames spent in WOBBLE before falling.
REQ-005 Parameter BREAK_DIST, default 32, minimum fall distance in pixels that breaks the bag.
REQ-006 Parameter BROKEN_FRAMES, default 150, lifetime in frames of a broken bag.
REQ-007 Parameter FLOOR_Y, default 11'd416, maximum Y; reaching it counts as landing.
REQ-008 clk  input  1  system clock; the block uses one clock.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 startOfFrame  input  1  one-cycle pulse at the start of each frame.
REQ-011 support_below  input  1  1 = terrain directly under the bag, valid on the startOfFrame cycle.
REQ-012 collision_gold  input  1  per-pixel player/alien overlap with the bag, from the collision stage.
REQ-013 player_eat_gold  input  1  per-pixel player overlap with a broken bag, from the collision stage.
REQ-014 gold_state  output  4  encoded bag state, consumed by the collision stage.
REQ-015 topLeftX, topLeftY  output  11 each  bag position for the bag drawer.
REQ-016 gold_visible  output  1  0 once the bag is GONE; gates the bag drawing request.
REQ-017 gold_eaten  output  1  one-cycle pulse when the bag is eaten, to scoring.

Function
REQ-018 Encoding: REST=0, FALLING=1, BROKEN=2, WOBBLE=3, GONE=4; collision logic treats 1 as lethal and 2 as edible.
REQ-019 collision_gold and player_eat_gold go into sticky flags on any cycle; the flags clear on the cycle after each startOfFrame.
REQ-020 All state, position and counter updates happen only on the startOfFrame cycle.
REQ-021 REST: support_below=0 -> WOBBLE, wobble counter loaded with WOBBLE_FRAMES.
REQ-022 WOBBLE: counter decrements each frame; support_below=1 -> REST; counter reaches 0 with no support -> FALLING, fall distance cleared.
REQ-023 FALLING: Y += FALL_SPEED, saturated at FLOOR_Y; fall distance += the same amount, saturating at 8 bits.
REQ-024 FALLING: landing = support_below=1 or Y==FLOOR_Y at the frame start; Y is not incremented on the landing frame.
REQ-025 On landing: fall distance >= BREAK_DIST -> BROKEN, broken counter loaded with BROKEN_FRAMES; otherwise -> REST.
REQ-026 BROKEN: eat flag set -> GONE, and gold_eaten pulses for exactly one cycle on the cycle after that startOfFrame.
REQ-027 GONE is absorbing until reset; gold_visible=0 and the position is frozen.
REQ-028 In REST and WOBBLE, the collision_gold flag has no effect on state; it is reserved for push logic.
REQ-029 If the eat flag and the broken-timer expiry occur on the same frame, eat wins: gold_eaten pulses.

Reset
REQ-030 Reset values: state REST, topLeftY=INIT_Y, topLeftX=INIT_X, gold_visible=1, gold_eaten=0, all counters and flags 0.
REQ-031 Reset asserted mid-fall or mid-wobble restores the REQ-030 values on the next clock edge; it has priority over startOfFrame.

Configuration
REQ-032 Macro GOLD_BROKEN_TIMEOUT_EN defined: BROKEN -> GONE when the broken counter reaches 0, with no gold_eaten pulse.
REQ-033 GOLD_BROKEN_TIMEOUT_EN undefined: the broken counter is absent and BROKEN persists until eaten.

Structure
REQ-034 Package digger_pkg holds the gold_state_t enum (4-bit encoding per REQ-018), the 11-bit coordinate typedef and FLOOR_Y.
REQ-035 One sub-module, frame_timer: a loadable down-counter that decrements on startOfFrame and flags zero, shared by the wobble and broken counters.

Verification
REQ-036 Bench covers: support_below=0 from REST for 15 frames -> state 3 for 15 frames, then 1; Y rises by 4 per frame.
REQ-037 Bench covers: support returns on wobble frame 7 -> state 0, Y unchanged at 96.
REQ-038 Bench covers: fall 40 px then support=1 -> state 2; player_eat_gold pulse mid-frame -> state 4 at the next frame, gold_eaten high 1 cycle, gold_visible=0.
REQ-039 Bench covers: fall 16 px then support=1 -> state 0 at Y=112.
REQ-040 Bench covers: no support from Y=400 -> Y saturates at 416, state 2; with GOLD_BROKEN_TIMEOUT_EN, GONE after 150 frames and no gold_eaten pulse.
REQ-041 Bench covers: reset asserted while FALLING at Y=200 -> the next cycle shows state 0, Y=96, counters cleared.
